// File: rtl/id_base_agu.sv
// ID-stage load/store address generation: base forwarding mux, offset add, load-use interlock.
// Optional misalignment flag is built only when AGU_MISALIGN_CHECK_EN is defined.
module id_base_agu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  select_i,
  input  logic [31:0] ID_base_data_i,
  input  logic [31:0] EX_result_i,
  input  logic [31:0] MEM_result_i,
  input  logic [31:0] WB_result_i,
  input  logic        EX_MemRead_i,
  input  logic        MEM_MemRead_i,
  input  logic        ID_memop_i,
  input  logic [15:0] ID_offset_i,
  input  logic [1:0]  ID_size_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] addr_o,
  output logic [1:0]  size_o,
  output logic        valid_o,
  output logic        misalign_o,
  output logic        stall_o,
  output logic [15:0] ilock_cnt_o
);

  logic [31:0] base_sel;
  logic [31:0] sum;
  logic        ilock;
  logic        misalign_calc;

  logic [31:0] addr_reg,     addr_next;
  logic [1:0]  size_reg,     size_next;
  logic        valid_reg,    valid_next;
  logic        misalign_reg, misalign_next;
  logic [15:0] cnt_reg,      cnt_next;

  always_comb begin
    base_sel = ID_base_data_i;
    unique case (select_i)
      2'b00: base_sel = ID_base_data_i;
      2'b01: base_sel = EX_result_i;
      2'b10: base_sel = MEM_result_i;
      2'b11: base_sel = WB_result_i;
      default: base_sel = ID_base_data_i;
    endcase
  end

  assign sum = base_sel + {{16{ID_offset_i[15]}}, ID_offset_i};

  // Load data only exists in WB, so forwarding from a load in EX or MEM must wait.
  assign ilock   = ID_memop_i & (((select_i == 2'b01) & EX_MemRead_i) |
                                 ((select_i == 2'b10) & MEM_MemRead_i));
  assign stall_o = ilock | stall_i;

`ifdef AGU_MISALIGN_CHECK_EN
  assign misalign_calc = ID_memop_i & (((ID_size_i == 2'b01) & sum[0]) |
                                       ((ID_size_i == 2'b10) & (sum[1:0] != 2'b00)) |
                                       (ID_size_i == 2'b11));
`else
  assign misalign_calc = 1'b0;
`endif

  always_comb begin
    addr_next     = addr_reg;
    size_next     = size_reg;
    valid_next    = valid_reg;
    misalign_next = misalign_reg;
    if (flush_i) begin
      valid_next    = 1'b0;
      misalign_next = 1'b0;
    end else if (stall_i) begin
      valid_next    = valid_reg;
    end else if (ilock) begin
      valid_next    = 1'b0;
      misalign_next = 1'b0;
    end else begin
      addr_next     = sum;
      size_next     = ID_size_i;
      valid_next    = ID_memop_i;
      misalign_next = misalign_calc;
    end
  end

  // Counter sees interlock cycles even when a flush squashes the bubble.
  always_comb begin
    cnt_next = cnt_reg;
    if (ilock && !stall_i && (cnt_reg != 16'hFFFF))
      cnt_next = cnt_reg + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_reg     <= 32'd0;
      size_reg     <= 2'd0;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      cnt_reg      <= 16'd0;
    end else begin
      addr_reg     <= addr_next;
      size_reg     <= size_next;
      valid_reg    <= valid_next;
      misalign_reg <= misalign_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign addr_o      = addr_reg;
  assign size_o      = size_reg;
  assign valid_o     = valid_reg;
  assign misalign_o  = misalign_reg;
  assign ilock_cnt_o = cnt_reg;

endmodule

// File: tb/tb_id_base_agu.sv
// Directed plus randomized bench for id_base_agu against an arithmetic reference model.
module tb_id_base_agu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  select_i;
  logic [31:0] ID_base_data_i, EX_result_i, MEM_result_i, WB_result_i;
  logic        EX_MemRead_i, MEM_MemRead_i, ID_memop_i;
  logic [15:0] ID_offset_i;
  logic [1:0]  ID_size_i;
  logic        stall_i, flush_i;
  logic [31:0] addr_o;
  logic [1:0]  size_o;
  logic        valid_o, misalign_o, stall_o;
  logic [15:0] ilock_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_addr;
  logic [1:0]  m_size;
  logic        m_valid, m_mis;
  int          m_cnt;

  always #5 clk_i = ~clk_i;

  id_base_agu dut (
    .clk_i(clk_i), .rst_i(rst_i), .select_i(select_i),
    .ID_base_data_i(ID_base_data_i), .EX_result_i(EX_result_i),
    .MEM_result_i(MEM_result_i), .WB_result_i(WB_result_i),
    .EX_MemRead_i(EX_MemRead_i), .MEM_MemRead_i(MEM_MemRead_i),
    .ID_memop_i(ID_memop_i), .ID_offset_i(ID_offset_i), .ID_size_i(ID_size_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .addr_o(addr_o), .size_o(size_o), .valid_o(valid_o),
    .misalign_o(misalign_o), .stall_o(stall_o), .ilock_cnt_o(ilock_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_misalign(input logic memop, input logic [1:0] sz,
                                        input logic [31:0] a);
`ifdef AGU_MISALIGN_CHECK_EN
    if (!memop) return 1'b0;
    case (sz)
      2'd0: return 1'b0;
      2'd1: return (a % 2) != 0;
      2'd2: return (a % 4) != 0;
      default: return 1'b1;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // Checks stall_o on current inputs, advances the model, clocks, checks registers.
  task automatic cycle(input string tag);
    logic [31:0] base, sum;
    logic        il;
    case (select_i)
      2'd0: base = ID_base_data_i;
      2'd1: base = EX_result_i;
      2'd2: base = MEM_result_i;
      default: base = WB_result_i;
    endcase
    sum = base + 32'($signed(ID_offset_i));
    il  = ID_memop_i && ((select_i == 2'd1 && EX_MemRead_i) ||
                         (select_i == 2'd2 && MEM_MemRead_i));
    #1;
    check({tag, ".stall_o"}, {31'd0, stall_o}, {31'd0, il || stall_i});
    if (rst_i) begin
      m_addr = 0; m_size = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
    end else begin
      if (il && !stall_i && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (flush_i) begin
        m_valid = 0; m_mis = 0;
      end else if (stall_i) begin
      end else if (il) begin
        m_valid = 0; m_mis = 0;
      end else begin
        m_addr = sum; m_size = ID_size_i; m_valid = ID_memop_i;
        m_mis = exp_misalign(ID_memop_i, ID_size_i, sum);
      end
    end
    @(posedge clk_i); #1;
    check({tag, ".addr"},  addr_o, m_addr);
    check({tag, ".size"},  {30'd0, size_o}, {30'd0, m_size});
    check({tag, ".valid"}, {31'd0, valid_o}, {31'd0, m_valid});
    check({tag, ".mis"},   {31'd0, misalign_o}, {31'd0, m_mis});
    check({tag, ".cnt"},   {16'd0, ilock_cnt_o}, m_cnt);
    $display("%-12s sel=%0d memop=%0b st=%0b fl=%0b -> addr=%h v=%0b mis=%0b cnt=%0d",
             tag, select_i, ID_memop_i, stall_i, flush_i, addr_o, valid_o, misalign_o, ilock_cnt_o);
  endtask

  task automatic randomize_inputs();
    select_i       = 2'($urandom);
    ID_base_data_i = $urandom; EX_result_i = $urandom;
    MEM_result_i   = $urandom; WB_result_i = $urandom;
    EX_MemRead_i   = 1'($urandom); MEM_MemRead_i = 1'($urandom);
    ID_memop_i     = 1'($urandom);
    ID_offset_i    = 16'($urandom);
    ID_size_i      = 2'($urandom);
  endtask

  task automatic quiet();
    rst_i = 0; stall_i = 0; flush_i = 0;
    EX_MemRead_i = 0; MEM_MemRead_i = 0;
  endtask

  initial begin
    m_addr = 0; m_size = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
    randomize_inputs();
    stall_i = 1'($urandom); flush_i = 1'($urandom); rst_i = 1;
    @(posedge clk_i); #1;

    // Reset with random inputs on the ports
    randomize_inputs(); cycle("reset0");
    randomize_inputs(); cycle("reset1");
    check("reset.addr", addr_o, 32'd0);
    check("reset.cnt", {16'd0, ilock_cnt_o}, 32'd0);

    // Plain store with negative offset
    quiet(); select_i = 2'd0; ID_base_data_i = 32'h1000; ID_offset_i = 16'hFFFC;
    ID_size_i = 2'd2; ID_memop_i = 1;
    cycle("store");
    check("store.addr_k", addr_o, 32'h0000_0FFC);
    check("store.valid_k", {31'd0, valid_o}, 32'd1);

    // Load-use interlock: EX match, MEM match, then WB forward
    select_i = 2'd1; EX_MemRead_i = 1; EX_result_i = 32'hDEAD_0000;
    cycle("ilock_ex");
    check("ilock_ex.valid_k", {31'd0, valid_o}, 32'd0);
    select_i = 2'd2; EX_MemRead_i = 0; MEM_MemRead_i = 1;
    cycle("ilock_mem");
    select_i = 2'd3; MEM_MemRead_i = 0; WB_result_i = 32'h0000_2000; ID_offset_i = 16'h0010;
    cycle("ilock_wb");
    check("ilock_wb.addr_k", addr_o, 32'h0000_2010);
    check("ilock_wb.cnt_k", {16'd0, ilock_cnt_o}, 32'd2);

    // No interlock without a memop
    ID_memop_i = 0; select_i = 2'd1; EX_MemRead_i = 1;
    cycle("nomemop");
    EX_MemRead_i = 0; ID_memop_i = 1;

    // Wrap-around
    select_i = 2'd0; ID_base_data_i = 32'hFFFF_FFF0; ID_offset_i = 16'h0020; ID_size_i = 2'd2;
    cycle("wrap");
    check("wrap.addr_k", addr_o, 32'h0000_0010);
    check("wrap.mis_k", {31'd0, misalign_o}, 32'd0);

    // Misaligned word
    ID_base_data_i = 32'h1000; ID_offset_i = 16'h0002;
    cycle("misalign");
`ifdef AGU_MISALIGN_CHECK_EN
    check("misalign.mis_k", {31'd0, misalign_o}, 32'd1);
`else
    check("misalign.mis_k", {31'd0, misalign_o}, 32'd0);
`endif
    check("misalign.valid_k", {31'd0, valid_o}, 32'd1);
    ID_size_i = 2'd3; ID_offset_i = 16'h0004;
    cycle("size11");

    // Flush and stall together, then a stall hold
    ID_size_i = 2'd2; ID_offset_i = 16'h0008;
    cycle("valid_op");
    flush_i = 1; stall_i = 1;
    cycle("flush_stall");
    check("flush_stall.valid_k", {31'd0, valid_o}, 32'd0);
    flush_i = 0;
    cycle("reload_hold");
    stall_i = 0;
    cycle("reload");
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      ID_base_data_i = $urandom; ID_offset_i = 16'($urandom);
      cycle("stall_hold");
    end
    stall_i = 0;

    // Flush during interlock still counts; reset mid-interlock clears
    select_i = 2'd1; EX_MemRead_i = 1; flush_i = 1;
    cycle("flush_ilock");
    flush_i = 0; rst_i = 1;
    cycle("rst_ilock");
    quiet();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      rst_i   = ($urandom_range(0, 49) == 0);
      cycle("rand");
    end

    // Counter saturation
    quiet(); ID_memop_i = 1; select_i = 2'd1; EX_MemRead_i = 1;
    cycle("sat_start");
    repeat (65540) @(posedge clk_i);
    #1;
    m_cnt = 65535;
    check("sat.cnt", {16'd0, ilock_cnt_o}, 32'h0000_FFFF);
    cycle("sat_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
